// File: rtl/scope_trace_if.sv
// Sample-input, trigger-control and pixel-query signals of the scope trace renderer.
// The master drives samples and pixel coordinates; the slave answers with the trace-hit flags.
interface scope_trace_if #(
  parameter int unsigned SAMPLE_W = 10,
  parameter int unsigned NUM_CH   = 2
);
  logic                         sample_valid;
  logic [NUM_CH*SAMPLE_W-1:0]   sample_in;
  logic                         mode;
  logic [SAMPLE_W-1:0]          trig_level;
  logic [9:0]                   DrawX;
  logic [9:0]                   DrawY;
  logic [NUM_CH-1:0]            is_shape;
  logic                         armed;
  logic                         triggered;

  modport master (
    output sample_valid, sample_in, mode, trig_level, DrawX, DrawY,
    input  is_shape, armed, triggered
  );

  modport slave (
    input  sample_valid, sample_in, mode, trig_level, DrawX, DrawY,
    output is_shape, armed, triggered
  );
endinterface

// File: rtl/scope_trace.sv
// Multi-channel oscilloscope trace renderer: rolling per-channel sample history with
// scroll/triggered capture and a fixed 2-cycle per-pixel "on trace" lookup.
module scope_trace #(
  parameter int unsigned SAMPLE_W = 10,
  parameter int unsigned COLS     = 640,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned THICK    = 1,
  parameter int unsigned Y_BASE   = 112
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk,
  scope_trace_if.slave     bus
);
  localparam int unsigned AW = $clog2(COLS);

  typedef enum logic [1:0] {StScroll, StArmed, StCapture, StHold} state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
  logic [AW-1:0]        disp_base_q;
  logic [SAMPLE_W-1:0]  prev_ch0_q, ch0;
  logic                 fc_q, fedge;
  logic                 mode_q, mode_chg;
  logic [COLS-1:0]      valid_q, valid_d;
  logic                 armed_q, trig_q;
  logic                 we;
  logic [AW-1:0]        waddr;

  logic [10:0]          sum;
  logic [AW-1:0]        rsub, raddr;
  logic [9:0]           x1_q, y1_q;
  logic                 rd_valid_q;
  logic [NUM_CH-1:0]    is_shape_q, is_shape_d;

  // Only the top 8 bits of a sample affect the rendered row, so only those are stored.
  logic [7:0]           mem_q [NUM_CH][COLS];
  logic [7:0]           rd_q  [NUM_CH];

  assign ch0        = bus.sample_in[SAMPLE_W-1:0];
  assign fedge      = frame_clk & ~fc_q;
  assign mode_chg   = bus.mode != mode_q;
  assign wr_ptr_nxt = (wr_ptr_q == AW'(COLS - 1)) ? '0 : wr_ptr_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    valid_d  = valid_q;
    we       = 1'b0;
    waddr    = wr_ptr_q;
    if (mode_chg) begin
      // A mode switch restarts history from column 0 and suppresses this cycle's write.
      wr_ptr_d = '0;
      valid_d  = '0;
      state_d  = bus.mode ? StArmed : StScroll;
    end else begin
      unique case (state_q)
        StScroll: begin
          if (bus.sample_valid) begin
            we                = 1'b1;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_nxt;
          end
        end
        StArmed: begin
          if (bus.sample_valid && (prev_ch0_q < bus.trig_level) &&
              (ch0 >= bus.trig_level)) begin
            we       = 1'b1;
            waddr    = '0;
            wr_ptr_d = AW'(1);
            valid_d  = '0;
            valid_d[0] = 1'b1;
            state_d  = StCapture;
          end
        end
        StCapture: begin
          if (bus.sample_valid) begin
            we                = 1'b1;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_nxt;
            if (wr_ptr_q == AW'(COLS - 1)) state_d = StHold;
          end
        end
        StHold: begin
          if (fedge) state_d = StArmed;
        end
        default: state_d = StScroll;
      endcase
    end
  end

  // Display address: base + column, folded back into range with one conditional subtract.
  always_comb begin
    sum   = 11'(disp_base_q) + 11'(bus.DrawX);
    rsub  = AW'((sum >= 11'(COLS)) ? sum - 11'(COLS) : sum);
    raddr = ({1'b0, bus.DrawX} >= 11'(COLS)) ? '0 : rsub;
  end

  always_ff @(posedge Clk) begin
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (we) mem_q[c][waddr] <= bus.sample_in[c*SAMPLE_W + SAMPLE_W - 1 -: 8];
      rd_q[c] <= mem_q[c][raddr];
    end
  end

  logic        in_x, in_y;
  logic [10:0] ys;
  logic signed [11:0] dy, ady;

  always_comb begin
    is_shape_d = '0;
    ys         = '0;
    dy         = '0;
    ady        = '0;
    in_x       = {1'b0, x1_q} < 11'(COLS);
    in_y       = ({1'b0, y1_q} >= 11'(Y_BASE)) && ({1'b0, y1_q} <= 11'(Y_BASE + 255));
    for (int c = 0; c < int'(NUM_CH); c++) begin
      ys  = 11'(Y_BASE + 255) - 11'(rd_q[c]);
      dy  = $signed({2'b00, y1_q}) - $signed({1'b0, ys});
      ady = dy[11] ? -dy : dy;
      is_shape_d[c] = in_x & in_y & rd_valid_q & (ady <= $signed(12'(THICK)));
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= bus.mode ? StArmed : StScroll;
      mode_q      <= bus.mode;
      wr_ptr_q    <= '0;
      disp_base_q <= '0;
      prev_ch0_q  <= '0;
      fc_q        <= 1'b0;
      valid_q     <= '0;
      armed_q     <= 1'b0;
      trig_q      <= 1'b0;
      x1_q        <= '0;
      y1_q        <= '0;
      rd_valid_q  <= 1'b0;
      is_shape_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= bus.mode;
      wr_ptr_q   <= wr_ptr_d;
      valid_q    <= valid_d;
      fc_q       <= frame_clk;
      if (bus.sample_valid) prev_ch0_q <= ch0;
      // Latched once per frame from the pre-write pointer so a frame never tears.
      if (fedge) disp_base_q <= mode_q ? '0 : wr_ptr_q;
      armed_q    <= (state_d == StArmed);
      trig_q     <= (state_d == StCapture) || (state_d == StHold);
      x1_q       <= bus.DrawX;
      y1_q       <= bus.DrawY;
      rd_valid_q <= valid_q[raddr];
      is_shape_q <= is_shape_d;
    end
  end

  assign bus.is_shape  = is_shape_q;
  assign bus.armed     = armed_q;
  assign bus.triggered = trig_q;
endmodule

// File: tb/tb_scope_trace.sv
// Directed bench for scope_trace: scroll render, range limits, wrap, trigger/hold,
// async reset mid-capture and mode toggling.
module tb_scope_trace;
  logic Clk;
  logic Reset;
  logic frame_clk;
  int   total;
  int   bad;

  scope_trace_if #(.SAMPLE_W(10), .NUM_CH(2)) bus ();

  scope_trace dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [9:0] c0, input logic [9:0] c1);
    bus.sample_in    = {c1, c0};
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic frame_edge();
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
    tick();
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y);
    bus.DrawX = x;
    bus.DrawY = y;
    tick();
    tick();
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    Reset            = 1'b0;
    frame_clk        = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.mode         = 1'b0;
    bus.trig_level   = '0;
    bus.DrawX        = '0;
    bus.DrawY        = '0;
    #5;
    chk("rst_is_shape", 32'(bus.is_shape), 32'd0);
    chk("rst_armed", 32'(bus.armed), 32'd0);
    chk("rst_triggered", 32'(bus.triggered), 32'd0);
    tick();
    #5 Reset = 1'b1;
    tick();

    pix(10'd0, 10'd112);
    chk("empty_col", 32'(bus.is_shape), 32'd0);

    // Scroll fill: ch0 -> row 112, ch1 (0x200) -> row 239
    for (int i = 0; i < 640; i++) push(10'h3FC, 10'h200);
    frame_edge();
    pix(10'd640, 10'd112);
    bus.DrawX = 10'd400;
    bus.DrawY = 10'd112;
    tick();
    chk("latency_1clk", 32'(bus.is_shape), 32'd0);
    tick();
    chk("latency_2clk", 32'(bus.is_shape), 32'b01);
    pix(10'd400, 10'd113);
    chk("thick_113", 32'(bus.is_shape), 32'b01);
    pix(10'd400, 10'd114);
    chk("thick_114", 32'(bus.is_shape), 32'b00);
    pix(10'd400, 10'd239);
    chk("ch1_239", 32'(bus.is_shape), 32'b10);
    pix(10'd640, 10'd112);
    chk("x_640", 32'(bus.is_shape), 32'd0);
    pix(10'd400, 10'd110);
    chk("y_110", 32'(bus.is_shape), 32'd0);

    // 641st sample wraps to column 0
    push(10'h3FC, 10'h000);
    frame_edge();
    chk("wrap_wr_ptr", 32'(dut.wr_ptr_q), 32'd1);
    chk("wrap_disp_base", 32'(dut.disp_base_q), 32'd1);
    pix(10'd639, 10'd367);
    chk("wrap_x639", 32'(bus.is_shape), 32'b10);
    pix(10'd638, 10'd239);
    chk("wrap_x638", 32'(bus.is_shape), 32'b10);

    // Triggered capture
    bus.trig_level = 10'h200;
    bus.mode       = 1'b1;
    tick();
    tick();
    chk("arm_armed", 32'(bus.armed), 32'd1);
    chk("arm_wr_ptr", 32'(dut.wr_ptr_q), 32'd0);
    push(10'h100, 10'h3FC);
    chk("arm_0x100", 32'(bus.armed), 32'd1);
    push(10'h1FF, 10'h3FC);
    chk("arm_0x1FF", 32'(bus.armed), 32'd1);
    chk("arm_not_trig", 32'(bus.triggered), 32'd0);
    push(10'h200, 10'h3FC);
    chk("trig_triggered", 32'(bus.triggered), 32'd1);
    chk("trig_armed", 32'(bus.armed), 32'd0);
    chk("trig_wr_ptr", 32'(dut.wr_ptr_q), 32'd1);
    frame_edge();
    chk("trig_disp_base", 32'(dut.disp_base_q), 32'd0);
    pix(10'd0, 10'd239);
    chk("trig_col0", 32'(bus.is_shape), 32'b01);
    pix(10'd5, 10'd239);
    chk("trig_col5_cleared", 32'(bus.is_shape), 32'd0);
    for (int i = 0; i < 638; i++) push(10'h300, 10'h3FC);
    chk("capture_wr_ptr", 32'(dut.wr_ptr_q), 32'd639);
    chk("capture_trig", 32'(bus.triggered), 32'd1);
    push(10'h300, 10'h3FC);
    chk("hold_wr_ptr", 32'(dut.wr_ptr_q), 32'd0);
    chk("hold_trig", 32'(bus.triggered), 32'd1);
    chk("hold_armed", 32'(bus.armed), 32'd0);
    push(10'h000, 10'h000);
    chk("hold_ignored_ptr", 32'(dut.wr_ptr_q), 32'd0);
    pix(10'd0, 10'd239);
    chk("hold_col0", 32'(bus.is_shape), 32'b01);
    pix(10'd639, 10'd175);
    chk("hold_col639", 32'(bus.is_shape), 32'b01);
    frame_edge();
    chk("rearm_armed", 32'(bus.armed), 32'd1);
    chk("rearm_trig", 32'(bus.triggered), 32'd0);

    // Async reset in the middle of a capture
    push(10'h200, 10'h3FC);
    chk("recap_trig", 32'(bus.triggered), 32'd1);
    push(10'h300, 10'h3FC);
    push(10'h300, 10'h3FC);
    pix(10'd0, 10'd239);
    chk("recap_col0", 32'(bus.is_shape), 32'b01);
    #3 Reset = 1'b0;
    #1;
    chk("async_is_shape", 32'(bus.is_shape), 32'd0);
    chk("async_trig", 32'(bus.triggered), 32'd0);
    chk("async_armed", 32'(bus.armed), 32'd0);
    tick();
    #5 Reset = 1'b1;
    tick();
    chk("post_rst_armed", 32'(bus.armed), 32'd1);
    pix(10'd0, 10'd239);
    chk("post_rst_col0", 32'(bus.is_shape), 32'd0);
    pix(10'd639, 10'd175);
    chk("post_rst_col639", 32'(bus.is_shape), 32'd0);

    // Mode toggle 1 -> 0 -> 1
    bus.mode = 1'b0;
    tick();
    chk("toggle_scroll_armed", 32'(bus.armed), 32'd0);
    for (int i = 0; i < 3; i++) push(10'h3FC, 10'h3FC);
    chk("toggle_wr_ptr3", 32'(dut.wr_ptr_q), 32'd3);
    pix(10'd1, 10'd112);
    chk("toggle_col1", 32'(bus.is_shape), 32'b11);
    bus.mode = 1'b1;
    push(10'h3FC, 10'h3FC);
    chk("toggle_wr_ptr0", 32'(dut.wr_ptr_q), 32'd0);
    chk("toggle_armed", 32'(bus.armed), 32'd1);
    pix(10'd1, 10'd112);
    chk("toggle_col1_cleared", 32'(bus.is_shape), 32'd0);
    pix(10'd3, 10'd112);
    chk("toggle_no_write", 32'(bus.is_shape), 32'd0);
    push(10'h3FC, 10'h3FC);
    chk("toggle_no_trig_ptr", 32'(dut.wr_ptr_q), 32'd0);
    chk("toggle_still_armed", 32'(bus.armed), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scope_trace.md
Name: scope_trace

Overview:
- Multi-channel oscilloscope-style waveform renderer for the VGA path.
- Stores a rolling history of audio samples per channel and answers per-pixel "on trace" queries from the VGA controller's DrawX/DrawY.
- Successor to the single-channel shape generator: adds parametrised channel count, history depth, trace thickness, and a triggered-capture mode.
- Display pointer is latched on frame_clk so a frame never tears.

Parameters:
- SAMPLE_W, 10, bits per sample per channel (unsigned, must be >= 8).
- COLS, 640, history depth and displayed columns.
- NUM_CH, 2, number of channels.
- THICK, 1, trace half-thickness in pixels.
- Y_BASE, 112, top row of the 256-row display band.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous, active-low reset.
- frame_clk  in  1  VGA frame strobe; rising edge detected synchronously in Clk domain.
- sample_valid  in  1  one-cycle strobe; sample_in is valid.
- sample_in  in  NUM_CH*SAMPLE_W  packed samples; channel 0 in LSBs.
- mode  in  1  0 = scroll, 1 = triggered.
- trig_level  in  SAMPLE_W  channel-0 rising-crossing threshold.
- DrawX  in  10  pixel column.
- DrawY  in  10  pixel row.
- is_shape  out  NUM_CH  per-channel trace-hit flag.
- armed  out  1  high in ARMED.
- triggered  out  1  high in CAPTURE or HOLD.

Behaviour:
- Reset (Reset=0, async):
  - is_shape=0, armed=0, triggered=0.
  - wr_ptr=0, disp_base=0, prev_ch0=0, frame_clk edge register=0.
  - State = SCROLL if mode=0, else ARMED.
  - RAM contents are not cleared. Memory that has never been written must render as 0 via a per-column valid bitmap cleared at reset.
- Storage:
  - One COLS-deep circular buffer per channel, shared wr_ptr, wrapping COLS-1 -> 0.
  - prev_ch0 updates on every sample_valid.
- States:
  - SCROLL: every sample_valid writes at wr_ptr and increments it.
  - ARMED: no writes. On sample_valid with prev_ch0 < trig_level and ch0 >= trig_level:
    - write the sample at address 0;
    - set wr_ptr=1;
    - clear the valid bitmap except column 0;
    - go to CAPTURE.
  - CAPTURE: writes as in SCROLL. The write at address COLS-1 goes to HOLD.
  - HOLD: no writes. A frame_clk rising edge goes to ARMED.
- Mode change (registered compare):
  - Any change of mode forces wr_ptr=0 and clears the valid bitmap.
  - Next state is SCROLL (mode=0) or ARMED (mode=1), regardless of the current state.
- Display base, updated on a frame_clk rising edge:
  - Scroll mode: disp_base <= wr_ptr, so the oldest sample is at the left.
  - Triggered mode: disp_base <= 0.
  - Writes arriving in the same cycle use the pre-write wr_ptr.
- Pixel pipeline, fixed latency 2 cycles from DrawX/DrawY to is_shape:
  - Stage 1: register DrawX/DrawY; compute addr = (disp_base + DrawX) mod COLS without a divider (single conditional subtract); issue RAM read.
  - Stage 2: for each channel c, compute y_s = Y_BASE + 255 - s[SAMPLE_W-1 -: 8] at 11-bit width. is_shape[c] = 1 iff all of:
    - DrawX < COLS;
    - Y_BASE <= DrawY <= Y_BASE+255;
    - |DrawY - y_s| <= THICK (signed 12-bit);
    - column valid.
- Simultaneous events:
  - A write to the same address as a read returns old data (read-before-write).
  - sample_valid and frame_clk edge in the same cycle: the write and the pointer latch both occur.

Test Plan:
- Scroll render: reset, mode=0, push 640 samples with ch0=10'h3FC (y_s=112), frame_clk edge.
  - DrawX=400, DrawY=112 -> is_shape[0]=1 exactly 2 Clk later.
  - DrawY=113 -> 1.
  - DrawY=114 -> 0.
- Out of range, same fill:
  - DrawX=640 -> is_shape=0.
  - DrawY=110 (outside band) -> 0.
  - Empty columns after reset -> 0.
- Wrap and scroll: push 641 samples, the last with ch1=10'h000 (y_s=367), frame_clk edge.
  - DrawX=639, DrawY=367 -> is_shape[1]=1.
  - disp_base=1.
- Trigger: mode=1, trig_level=10'h200, ch0 sequence 0x100, 0x1FF, 0x200.
  - armed=1 until the 0x200 sample, then triggered=1.
  - After 639 more samples the state is HOLD and further samples are ignored.
  - A frame_clk edge returns to armed=1.
- Reset mid-CAPTURE: assert Reset asynchronously (no clock edge).
  - Outputs go to 0 immediately.
  - After release all pixels read 0 until new samples arrive.
- Mode toggle mid-SCROLL 1 -> 0 -> 1:
  - wr_ptr returns to 0 and the state is ARMED.
  - No write occurs while mode toggles.
